// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte requesters with round-robin
//   arbitration. Each requester owns a one-byte holding slot. One byte at a time
//   is launched to the UART and the arbiter waits for the UART done pulse (or the
//   watchdog) before granting again, followed by an optional inter-frame gap.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   i_Req_Valid      per-requester byte offer
//   i_Req_Byte       per-requester byte, requester k at [8k+7:8k]
//   o_Req_Ready      slot k empty (= ~pending[k])
//   o_Req_Done       1-clk pulse: requester k byte fully sent
//   o_TX_Data_Valid  1-clk launch strobe to the UART
//   o_TX_Byte        byte to the UART, held from launch until the next grant
//   i_TX_Done        done indication from the UART (rising edge used)
//   o_Grant_Id       index of current/last granted requester
//   o_Busy           high whenever the FSM is not idle
//   o_Timeout        1-clk pulse: watchdog expired, in-flight byte dropped
module uart_tx_arbiter #(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned GAP_CYCLES     = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 2048,
  localparam int unsigned GW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Req_Done,
  output logic                 o_TX_Data_Valid,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Done,
  output logic [GW-1:0]        o_Grant_Id,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  // Terminal values: the watchdog fires on the edge that ends the
  // TIMEOUT_CYCLES-th BUSY cycle; the gap ends after GAP_CYCLES cycles.
  localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [7:0]           slot_q [NUM_REQ];
  logic [7:0]           slot_d [NUM_REQ];
  logic [GW-1:0]        grant_q, grant_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic                 timeout_q, timeout_d;
  logic                 done_q;

  logic                 done_rise;
  logic                 found;
  logic [GW-1:0]        pick;

  assign done_rise = i_TX_Done & ~done_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    slot_d     = slot_q;
    grant_d    = grant_q;
    tx_byte_d  = tx_byte_q;
    cnt_d      = cnt_q;
    req_done_d = '0;
    timeout_d  = 1'b0;
    found      = 1'b0;
    pick       = grant_q;

    // Round-robin scan starting just after the last grant.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!found && pending_q[GW'((32'(grant_q) + i) % NUM_REQ)]) begin
        found = 1'b1;
        pick  = GW'((32'(grant_q) + i) % NUM_REQ);
      end
    end

    // Slot capture; never collides with a clear since a clear needs pending=1.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (i_Req_Valid[k] && !pending_q[k]) begin
        pending_d[k] = 1'b1;
        slot_d[k]    = i_Req_Byte[8*k +: 8];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d   = pick;
          tx_byte_d = slot_q[pick];
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (done_rise) begin
          req_done_d[grant_q] = 1'b1;
          pending_d[grant_q]  = 1'b0;
          cnt_d               = '0;
          state_d             = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          timeout_d          = 1'b1;
          pending_d[grant_q] = 1'b0;
          cnt_d              = '0;
          state_d            = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) slot_q[k] <= '0;
      grant_q    <= GW'(NUM_REQ - 1);
      tx_byte_q  <= '0;
      cnt_q      <= '0;
      req_done_q <= '0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      slot_q     <= slot_d;
      grant_q    <= grant_d;
      tx_byte_q  <= tx_byte_d;
      cnt_q      <= cnt_d;
      req_done_q <= req_done_d;
      timeout_q  <= timeout_d;
      done_q     <= i_TX_Done;
    end
  end

  assign o_Req_Ready     = ~pending_q;
  assign o_Req_Done      = req_done_q;
  assign o_TX_Data_Valid = (state_q == S_LAUNCH);
  assign o_TX_Byte       = tx_byte_q;
  assign o_Grant_Id      = grant_q;
  assign o_Busy          = (state_q != S_IDLE);
  assign o_Timeout       = timeout_q;

endmodule
